// File: rtl/twiddle_apply75.sv
// Streaming twiddle applicator between the two sub-DFT stages of a 75-point DFT.
// Walks a row*col mod 75 table address per sample, multiplies by W75^k (Q10), rounds and saturates.
module twiddle_apply75 #(
    parameter int WIDTH   = 16,
    parameter int N1      = 15,
    parameter int N2      = 5,
    parameter int INVERSE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic [10:0]             tw_addr,
    input  logic signed [17:0]      tw_re,
    input  logic signed [17:0]      tw_im,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    frame_err
);
    localparam int PW = WIDTH + 19;
    localparam int SW = WIDTH + 20;
    localparam logic [6:0] COL_LAST = 7'(N2 - 1);
    localparam logic [6:0] ROW_LAST = 7'(N1 - 1);
    localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic [6:0] col, row, step, acc;
    logic [6:0] e_col, e_row, e_step, e_acc;
    logic [7:0] acc_sum;
    logic       at_zero, is_last;

    // in_sof restarts the walk: the sample is handled as if all counters were already zero
    always_comb begin
        at_zero = (col == '0) && (row == '0);
        e_col   = in_sof ? '0 : col;
        e_row   = in_sof ? '0 : row;
        e_step  = in_sof ? '0 : step;
        e_acc   = in_sof ? '0 : acc;
        acc_sum = {1'b0, e_acc} + {1'b0, e_step};
        is_last = (e_row == ROW_LAST) && (e_col == COL_LAST);
    end

    assign tw_addr = (in_valid && in_sof) ? '0 : {4'b0000, acc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            step <= '0;
            acc  <= '0;
        end else if (in_valid) begin
            if (e_col != COL_LAST) begin
                col  <= e_col + 7'd1;
                acc  <= (acc_sum >= 8'd75) ? 7'(acc_sum - 8'd75) : acc_sum[6:0];
                row  <= e_row;
                step <= e_step;
            end else begin
                col <= '0;
                acc <= '0;
                if (e_row == ROW_LAST) begin
                    row  <= '0;
                    step <= '0;
                end else begin
                    row  <= e_row + 7'd1;
                    step <= (e_step == 7'd74) ? '0 : e_step + 7'd1;
                end
            end
        end
    end

    logic                    s1_v, s1_sof, s1_eof, s1_err, s1_id;
    logic signed [WIDTH-1:0] s1_re, s1_im;
    logic signed [17:0]      s1_wr;
    logic signed [18:0]      s1_wi;
    logic                    s2_v, s2_sof, s2_eof, s2_err, s2_id;
    logic signed [WIDTH-1:0] s2_re, s2_im;
    logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;

    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] s;
        s = (v + SW'(512)) >>> 10;
        if (s > MAXV)      return MAXV[WIDTH-1:0];
        else if (s < MINV) return MINV[WIDTH-1:0];
        else               return s[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s1_sof <= 1'b0; s1_eof <= 1'b0; s1_err <= 1'b0; s1_id <= 1'b0;
            s1_re <= '0; s1_im <= '0; s1_wr <= '0; s1_wi <= '0;
            s2_v <= 1'b0; s2_sof <= 1'b0; s2_eof <= 1'b0; s2_err <= 1'b0; s2_id <= 1'b0;
            s2_re <= '0; s2_im <= '0;
            p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
            out_valid <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0; frame_err <= 1'b0;
            out_re <= '0; out_im <= '0;
        end else begin
            s1_v   <= in_valid;
            s1_sof <= in_valid && (in_sof || at_zero);
            s1_eof <= in_valid && is_last;
            s1_err <= in_valid && in_sof && !at_zero;
            s1_id  <= (tw_addr == '0);
            s1_re  <= in_re;
            s1_im  <= in_im;
            s1_wr  <= tw_re;
            s1_wi  <= (INVERSE != 0) ? -19'(tw_im) : 19'(tw_im);

            s2_v   <= s1_v;
            s2_sof <= s1_sof;
            s2_eof <= s1_eof;
            s2_err <= s1_err;
            s2_id  <= s1_id;
            s2_re  <= s1_re;
            s2_im  <= s1_im;
            p_rr   <= PW'(s1_re) * PW'(s1_wr);
            p_ii   <= PW'(s1_im) * PW'(s1_wi);
            p_ri   <= PW'(s1_re) * PW'(s1_wi);
            p_ir   <= PW'(s1_im) * PW'(s1_wr);

            out_valid <= s2_v;
            out_sof   <= s2_sof;
            out_eof   <= s2_eof;
            frame_err <= s2_err;
            // Address 0 bypasses the multiplier so the identity holds regardless of table contents
            out_re <= s2_id ? s2_re : round_sat(SW'(p_rr) - SW'(p_ii));
            out_im <= s2_id ? s2_im : round_sat(SW'(p_ri) + SW'(p_ir));
        end
    end
endmodule
